lsu_access_ctrl: RTL and testbench
==================================

// Module: lsu_access_ctrl
// PURPOSE
//  Load/store access controller, directly upstream of the word-addressed data memory.
//  Turns core byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word reads/writes.
//  Sub-word stores use read-modify-write; load data is lane-extracted and sign/zero-extended.
//  Misaligned, unsupported or out-of-range accesses return an error and never touch memory.
// PARAMETERS
//  MEM_DEPTH  64  number of 32-bit words in data memory; word index >= MEM_DEPTH is an error
// PORTS
//  clk        in   1   sole clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  req_valid  in   1   core request present
//  req_ready  out  1   controller idle; request accepted when valid && ready
//  req_write  in   1   1=store, 0=load
//  req_funct3 in   3   RV32I funct3 (load: 0,1,2,4,5; store: 0,1,2)
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data (low byte/half used for SB/SH)
//  rsp_valid  out  1   one-cycle response pulse
//  rsp_rdata  out  32  extended load data; 0 for stores and errors
//  rsp_err    out  1   valid with rsp_valid: misaligned/unsupported/out-of-range
//  mem_addr   out  32  word index = req_addr[31:2], zero-extended
//  mem_wdata  out  32  word to write
//  mem_read   out  1   memory read enable (mem_rdata valid the same cycle)
//  mem_write  out  1   memory write enable, committed at the next rising clk edge
//  mem_rdata  in   32  combinational read data from memory
// BEHAVIOUR
//  States: IDLE, LD_RD, ST_RD, ST_WR, RSP. All registered state/data reset asynchronously.
//  Reset: state=IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; mem_read=mem_write=0,
//   mem_addr=0, mem_wdata=0. mem_read/mem_write/rsp_valid are decoded from state, so they drop
//   as soon as reset asserts; a write in flight is abandoned and never issued.
//  IDLE: req_ready=1. On accept at cycle T, register addr, wdata, funct3, write and the error check.
//   err -> RSP; LW/LB/LH/LBU/LHU -> LD_RD; SW -> ST_WR; SB/SH -> ST_RD.
//  Errors:
//   - LH/LHU/SH with addr[0]=1.
//   - LW/SW with addr[1:0]!=0.
//   - Unsupported funct3 (load 3,6,7; store >=3).
//   - addr[31:2] >= MEM_DEPTH.
//  LD_RD: mem_read=1; lane = addr[1:0] (byte) or addr[1] (half).
//   Byte lane b = rdata[8b+7:8b]; LB/LH sign-extend, LBU/LHU zero-extend. Result registered -> RSP.
//  ST_RD: mem_read=1; merge req_wdata into the old word at the addressed lane, others kept;
//   merged word registered -> ST_WR.
//  ST_WR: mem_write=1, mem_wdata = merged word (SB/SH) or req_wdata (SW) -> RSP.
//  RSP: rsp_valid=1 for exactly one cycle, no backpressure -> IDLE; req_ready=0 in all non-IDLE states.
//  Latency accept->rsp_valid: error 1, load 2, SW 2, SB/SH 3 cycles.
//   Back-to-back: next accept in the cycle after RSP.
//  mem_addr holds the registered word index in every non-IDLE state; 0 in IDLE.
//   mem_read and mem_write are never both 1.
// STRUCTURE
//  Package lsu_pkg: funct3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5) and the state enum.
//  Sub-module lsu_lane_align (combinational): load extract/extend and store lane merge;
//   inputs word, offset[1:0], funct3, wdata.
// TESTING
//  T1 reset: hold reset=0 -> req_ready=1, all mem_*/rsp_* 0; deassert, outputs unchanged.
//  T2 SW addr=0x10 wdata=0xDEADBEEF -> mem_write=1 at T+1, mem_addr=4;
//   rsp_valid at T+2 with err=0; LW 0x10 -> rsp_rdata=0xDEADBEEF at T+2.
//  T3 word 4=0xDEADBEEF; SB addr=0x13 wdata=0x5A -> read at T+1, write 0x5AADBEEF at T+2,
//   rsp at T+3; LB 0x13 -> 0x0000005A; LBU 0x12 -> 0x000000AD; LB 0x12 -> 0xFFFFFFAD.
//  T4 LH addr=0x11 and SW addr=0x12 -> rsp_err=1 at T+1, mem_read/mem_write never asserted;
//   LW addr=0x100 (word 64) -> rsp_err=1.
//  T5 SH addr=0x16 wdata=0x1234_8001 over word 0 -> word 5=0x80010000;
//   LH 0x16 -> 0xFFFF8001, LHU 0x16 -> 0x00008001.
//  T6 assert reset during ST_RD of an SB -> mem_read drops asynchronously, no write ever occurs,
//   memory word unchanged, next request serviced normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants, state type and request error check for the load/store access controller.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD_RD = 3'd1,
        S_ST_RD = 3'd2,
        S_ST_WR = 3'd3,
        S_RSP   = 3'd4
    } lsu_state_e;

    // Misaligned, unsupported for the direction, or beyond the memory depth.
    function automatic logic access_err(input logic        write,
                                        input logic [2:0]  funct3,
                                        input logic [31:0] addr,
                                        input logic [31:0] depth);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = write;
            F3_H:    bad = addr[0];
            F3_HU:   bad = write | addr[0];
            F3_W:    bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= depth) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: load byte/half extraction with extension, and store lane merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        byte_shifted = word >> {offset, 3'b000};
        half_shifted = word >> {offset[1], 4'b0000};
        ld_byte      = byte_shifted[7:0];
        ld_half      = half_shifted[15:0];

        case (funct3)
            F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_data = {24'h000000, ld_byte};
            F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_data = {16'h0000, ld_half};
            default: load_data = word;
        endcase

        store_word = word;
        case (funct3)
            F3_B:    store_word[{offset, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store access controller: byte-addressed core requests to word memory, RMW for sub-word stores.
//  state   | meaning
//  S_IDLE  | ready for a request, memory idle
//  S_LD_RD | memory read, extracted load data captured
//  S_ST_RD | memory read for sub-word store, merged word captured
//  S_ST_WR | memory write of merged or full word
//  S_RSP   | one-cycle response pulse
module lsu_access_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        write_q;
    logic        err_q;
    logic [31:0] data_q;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_err = access_err(req_write, req_funct3, req_addr, 32'(MEM_DEPTH));

    lsu_lane_align u_lane_align (
        .word       (mem_rdata),
        .offset     (addr_q[1:0]),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Strobes decode straight from state so an asserted reset removes them immediately.
    assign req_ready = (state == S_IDLE);
    assign mem_read  = (state == S_LD_RD) || (state == S_ST_RD);
    assign mem_write = (state == S_ST_WR);
    assign rsp_valid = (state == S_RSP);
    assign rsp_err   = (state == S_RSP) && err_q;
    assign rsp_rdata = (state == S_RSP && !write_q && !err_q) ? data_q : 32'h0;
    assign mem_addr  = (state == S_IDLE) ? 32'h0 : {2'b00, addr_q[31:2]};
    assign mem_wdata = (state == S_ST_WR) ? data_q : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            funct3_q <= 3'd0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        funct3_q <= req_funct3;
                        write_q  <= req_write;
                        err_q    <= req_err;
                        // Full-word stores go straight to the write with the core's data.
                        data_q   <= req_write ? req_wdata : 32'h0;
                        if (req_err)
                            state <= S_RSP;
                        else if (!req_write)
                            state <= S_LD_RD;
                        else if (req_funct3 == F3_W)
                            state <= S_ST_WR;
                        else
                            state <= S_ST_RD;
                    end
                end
                S_LD_RD: begin
                    data_q <= load_data;
                    state  <= S_RSP;
                end
                S_ST_RD: begin
                    data_q <= store_word;
                    state  <= S_ST_WR;
                end
                S_ST_WR: state <= S_RSP;
                S_RSP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Self-checking bench: directed vector table, reset-abort sequence, and random traffic vs a byte-level model.
module tb_lsu_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] tb_mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        mem_clr;
    int          wr_count;
    int          n_checks;
    int          n_fail;

    lsu_access_ctrl #(.MEM_DEPTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= 32'h0;
        end else if (mem_write) begin
            tb_mem[mem_addr[5:0]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory semantics with plain arithmetic.
    task automatic ref_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output logic err,
                              output logic [31:0] rd, output int lat);
        logic        sup;
        int          size;
        int          sh;
        int          idx;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] v;
        sup  = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err  = !sup || ((a % size) != 0) || ((a / 4) >= 64);
        rd   = 32'h0;
        lat  = err ? 1 : (!w ? 2 : (size == 4 ? 2 : 3));
        if (!err) begin
            idx  = int'(a / 4);
            sh   = int'(a % 4) * 8;
            word = ref_mem[idx];
            mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
            if (!w) begin
                v = (word >> sh) & mask;
                if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end else begin
                ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
            end
        end
    endtask

    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic exp_err,
                           input logic [31:0] exp_rd, input int exp_lat, input string tag);
        int          lat;
        int          nrd;
        int          nwr;
        int          both;
        int          wr_cyc;
        logic        got_err;
        logic [31:0] got_rd;
        logic [31:0] wr_addr;
        int          exp_nrd;
        int          exp_nwr;
        lat = -1; nrd = 0; nwr = 0; both = 0; wr_cyc = 0;
        got_err = 1'b0; got_rd = 32'h0; wr_addr = 32'h0;
        @(negedge clk);
        check({tag, " idle_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, " idle_no_rsp"}, {31'd0, rsp_valid}, 32'd0);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                wr_addr = mem_addr;
                wr_cyc  = k;
            end
            if (mem_read && mem_write) both++;
            if (rsp_valid) begin
                lat     = k;
                got_err = rsp_err;
                got_rd  = rsp_rdata;
                break;
            end
        end
        exp_nrd = (!exp_err && (!w || f3 != 3'd2)) ? 1 : 0;
        exp_nwr = (!exp_err && w) ? 1 : 0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rsp_err"}, {31'd0, got_err}, {31'd0, exp_err});
        check({tag, " rsp_rdata"}, got_rd, exp_rd);
        check({tag, " read_cycles"}, nrd, exp_nrd);
        check({tag, " write_cycles"}, nwr, exp_nwr);
        check({tag, " rd_wr_overlap"}, both, 0);
        if (exp_nwr == 1) begin
            check({tag, " write_addr"}, wr_addr, {2'b00, a[31:2]});
            check({tag, " write_cycle"}, wr_cyc, exp_lat - 1);
            check({tag, " mem_word"}, tb_mem[a[7:2]], ref_mem[a[7:2]]);
        end
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vt [18];

    initial begin
        logic        m_err;
        logic [31:0] m_rd;
        int          m_lat;
        int          wr_before;
        logic        rw;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rwd;

        vt[0]  = '{1'b1, 3'd2, 32'h10,  32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 2};
        vt[1]  = '{1'b0, 3'd2, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF, 2};
        vt[2]  = '{1'b1, 3'd0, 32'h13,  32'h0000_005A, 1'b0, 32'h0000_0000, 3};
        vt[3]  = '{1'b0, 3'd2, 32'h10,  32'h0,         1'b0, 32'h5AAD_BEEF, 2};
        vt[4]  = '{1'b0, 3'd0, 32'h13,  32'h0,         1'b0, 32'h0000_005A, 2};
        vt[5]  = '{1'b0, 3'd4, 32'h12,  32'h0,         1'b0, 32'h0000_00AD, 2};
        vt[6]  = '{1'b0, 3'd0, 32'h12,  32'h0,         1'b0, 32'hFFFF_FFAD, 2};
        vt[7]  = '{1'b0, 3'd1, 32'h11,  32'h0,         1'b1, 32'h0000_0000, 1};
        vt[8]  = '{1'b1, 3'd2, 32'h12,  32'h1111_1111, 1'b1, 32'h0000_0000, 1};
        vt[9]  = '{1'b0, 3'd2, 32'h100, 32'h0,         1'b1, 32'h0000_0000, 1};
        vt[10] = '{1'b1, 3'd1, 32'h16,  32'h1234_8001, 1'b0, 32'h0000_0000, 3};
        vt[11] = '{1'b0, 3'd2, 32'h14,  32'h0,         1'b0, 32'h8001_0000, 2};
        vt[12] = '{1'b0, 3'd1, 32'h16,  32'h0,         1'b0, 32'hFFFF_8001, 2};
        vt[13] = '{1'b0, 3'd5, 32'h16,  32'h0,         1'b0, 32'h0000_8001, 2};
        vt[14] = '{1'b0, 3'd3, 32'h0,   32'h0,         1'b1, 32'h0000_0000, 1};
        vt[15] = '{1'b1, 3'd4, 32'h0,   32'h0000_00FF, 1'b1, 32'h0000_0000, 1};
        vt[16] = '{1'b0, 3'd2, 32'hFC,  32'h0,         1'b0, 32'h0000_0000, 2};
        vt[17] = '{1'b1, 3'd0, 32'h100, 32'h0000_0077, 1'b1, 32'h0000_0000, 1};

        n_checks = 0; n_fail = 0; wr_count = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        mem_clr = 1'b1;
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        check("rst ready", {31'd0, req_ready}, 32'd1);
        check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        check("rst mem_read", {31'd0, mem_read}, 32'd0);
        check("rst mem_write", {31'd0, mem_write}, 32'd0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst ready", {31'd0, req_ready}, 32'd1);
        check("post_rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_rst mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("post_rst mem_addr", mem_addr, 32'h0);

        for (int i = 0; i < 18; i++) begin
            ref_access(vt[i].w, vt[i].f3, vt[i].addr, vt[i].wdata, m_err, m_rd, m_lat);
            run_txn(vt[i].w, vt[i].f3, vt[i].addr, vt[i].wdata,
                    vt[i].err, vt[i].rdata, vt[i].lat, $sformatf("vec%0d", i));
        end

        // Reset lands while a byte store is in its read phase; the write must never issue.
        ref_access(1'b1, 3'd2, 32'h20, 32'hCAFE_F00D, m_err, m_rd, m_lat);
        run_txn(1'b1, 3'd2, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0, 2, "abort_setup");
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h21; req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort mem_read_before", {31'd0, mem_read}, 32'd1);
        wr_before = wr_count;
        #2 reset = 1'b0;
        #1;
        check("abort mem_read_async", {31'd0, mem_read}, 32'd0);
        check("abort mem_write_async", {31'd0, mem_write}, 32'd0);
        check("abort ready_async", {31'd0, req_ready}, 32'd1);
        check("abort mem_addr_async", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort no_write", wr_count, wr_before);
        check("abort word_kept", tb_mem[8], 32'hCAFE_F00D);
        run_txn(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D, 2, "abort_reload");

        for (int n = 0; n < 250; n++) begin
            rw  = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 9) == 0) ? $urandom() : $urandom_range(0, 279);
            rwd = $urandom();
            ref_access(rw, rf3, ra, rwd, m_err, m_rd, m_lat);
            run_txn(rw, rf3, ra, rwd, m_err, m_rd, m_lat, $sformatf("rnd%0d", n));
        end

        for (int i = 0; i < 64; i++) begin
            if (tb_mem[i] !== ref_mem[i]) check($sformatf("final word%0d", i), tb_mem[i], ref_mem[i]);
            else n_checks++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
